// File: rtl/testport_pkg.sv
// rtl/testport_pkg.sv - shared constants, FSM encoding and FIFO entry type for the test-port writer
package testport_pkg;

  localparam logic [29:0] TEST_PORT = 30'hFF;
  localparam logic [31:0] BEGIN_SYM = 32'h0000_0932;
  localparam logic [31:0] END_SYM   = 32'h0000_0D5D;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BEGIN  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_END    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/test_port_writer_if.sv
// rtl/test_port_writer_if.sv - result stream, control and memory write-port bundle
interface test_port_writer_if;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        mem_stall;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;
  logic        busy;
  logic        done;
  logic [15:0] sent_count;

  modport slave (
    input  start, in_valid, in_data, in_last, mem_stall,
    output in_ready, addr, data, wen, busy, done, sent_count
  );

  modport master (
    output start, in_valid, in_data, in_last, mem_stall,
    input  in_ready, addr, data, wen, busy, done, sent_count
  );
endinterface

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous result buffer holding {last, data} entries
module result_fifo
  import testport_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t wdata,
  output fifo_entry_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop & ~empty;
    // A full buffer still takes a word when the head leaves in the same cycle
    do_push = push & (~full | do_pop);
    rdata   = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/test_port_writer.sv
// rtl/test_port_writer.sv - writes begin symbol, buffered result words and end symbol to the test port
module test_port_writer #(
  parameter logic [29:0] TEST_PORT  = testport_pkg::TEST_PORT,
  parameter logic [31:0] BEGIN_SYM  = testport_pkg::BEGIN_SYM,
  parameter logic [31:0] END_SYM    = testport_pkg::END_SYM,
  parameter int          FIFO_DEPTH = 4,
  parameter int          GAP_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  test_port_writer_if.slave tp
);
  import testport_pkg::*;

  localparam int            GW         = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYCLES - 1);

  logic [2:0]    state;
  logic [GW-1:0] gap_cnt;
  logic          wen_r;
  logic [31:0]   data_r;
  logic          cur_last;
  logic          last_seen;
  logic [15:0]   sent_count;

  fifo_entry_t   head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_clr;
  logic          fifo_pop;
  logic          push;
  logic          accepting;
  logic          complete;
  logic          gap_ok;

  always_comb begin
    accepting = ((state == S_BEGIN) || (state == S_STREAM)) & ~fifo_full & ~last_seen;
    push      = tp.in_valid & accepting;
    complete  = wen_r & ~tp.mem_stall;
    gap_ok    = (gap_cnt == '0);
    fifo_pop  = (state == S_STREAM) & ~wen_r & gap_ok & ~fifo_empty;
    fifo_clr  = ((state == S_IDLE) || (state == S_DONE)) & tp.start;
  end

  assign tp.in_ready   = accepting;
  assign tp.wen        = wen_r;
  assign tp.addr       = wen_r ? TEST_PORT : '0;
  assign tp.data       = data_r;
  assign tp.busy       = (state == S_BEGIN) || (state == S_STREAM) || (state == S_END);
  assign tp.done       = (state == S_DONE);
  assign tp.sent_count = sent_count;

  result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (push),
    .pop   (fifo_pop),
    .wdata ({tp.in_last, tp.in_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      gap_cnt    <= '0;
      wen_r      <= 1'b0;
      data_r     <= '0;
      cur_last   <= 1'b0;
      last_seen  <= 1'b0;
      sent_count <= '0;
    end else begin
      if (!wen_r && !gap_ok)
        gap_cnt <= gap_cnt - 1'b1;
      if (push && tp.in_last)
        last_seen <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (tp.start) begin
            state      <= S_BEGIN;
            sent_count <= '0;
            last_seen  <= 1'b0;
            // A restart straight out of DONE may still owe gap cycles to the END beat
            if (gap_ok) begin
              wen_r  <= 1'b1;
              data_r <= BEGIN_SYM;
            end
          end
        end
        S_BEGIN: begin
          if (complete) begin
            wen_r   <= 1'b0;
            data_r  <= '0;
            gap_cnt <= GAP_RELOAD;
            state   <= S_STREAM;
          end else if (!wen_r && gap_ok) begin
            wen_r  <= 1'b1;
            data_r <= BEGIN_SYM;
          end
        end
        S_STREAM: begin
          if (complete) begin
            wen_r   <= 1'b0;
            data_r  <= '0;
            gap_cnt <= GAP_RELOAD;
            if (sent_count != 16'hFFFF)
              sent_count <= sent_count + 1'b1;
            if (cur_last)
              state <= S_END;
          end else if (fifo_pop) begin
            wen_r    <= 1'b1;
            data_r   <= head.data;
            cur_last <= head.last;
          end
        end
        S_END: begin
          if (complete) begin
            wen_r   <= 1'b0;
            data_r  <= '0;
            gap_cnt <= GAP_RELOAD;
            state   <= S_DONE;
          end else if (!wen_r && gap_ok) begin
            wen_r  <= 1'b1;
            data_r <= END_SYM;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_port_writer.sv
// tb/tb_test_port_writer.sv - randomized self-checking bench for test_port_writer
module tb_test_port_writer;
  import testport_pkg::*;

  localparam int G     = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  test_port_writer_if tif();

  test_port_writer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(G)) dut (
    .clk (clk),
    .rst (rst),
    .tp  (tif)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a report is BEGIN_SYM, every offered word in order, END_SYM
  logic [31:0] exp_q[$];
  logic [31:0] words[$];
  int          beat_len_q[$];
  int          comp_cnt  = 0;
  int          low_run   = 0;
  int          min_gap   = 1000;
  int          hi_cnt    = 0;
  int          nready    = 0;
  bit          have_prev = 0;
  bit          prev_wen  = 0;
  bit          prev_stall = 0;
  bit          done_next = 0;
  logic [31:0] prev_data = '0;
  bit          stall_en  = 0;
  bit          burst_req = 0;
  bit          stray     = 0;

  always @(negedge clk) begin
    if (!rst) begin
      have_prev  = 0;
      prev_wen   = 0;
      prev_stall = 0;
      hi_cnt     = 0;
      done_next  = 0;
    end else begin
      if (done_next) begin
        check("done_timing", tif.done, 1);
        done_next = 0;
      end
      if (prev_wen && !prev_stall) check("wen_drop", tif.wen, 0);
      if (prev_wen && prev_stall) begin
        check("wen_hold", tif.wen, 1);
        check("data_hold", tif.data, prev_data);
      end
      if (tif.wen) begin
        check("addr", {2'b00, tif.addr}, {2'b00, TEST_PORT});
        if (!prev_wen && have_prev) begin
          check("gap_min", low_run >= G, 1);
          if (low_run < min_gap) min_gap = low_run;
        end
        hi_cnt++;
        if (!tif.mem_stall) begin
          if (exp_q.size() == 0) begin
            check("extra_write", 0, 1);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("wdata", tif.data, e);
            if (e == END_SYM && exp_q.size() == 0) begin
              check("done_early", tif.done, 0);
              done_next = 1;
            end
          end
          beat_len_q.push_back(hi_cnt);
          hi_cnt    = 0;
          comp_cnt++;
          have_prev = 1;
          low_run   = 0;
        end
      end else begin
        check("data_idle", tif.data, 0);
        if (have_prev) low_run++;
      end
      prev_wen   = tif.wen;
      prev_stall = tif.mem_stall;
      prev_data  = tif.data;
    end
  end

  initial begin
    tif.mem_stall = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (burst_req && tif.wen && comp_cnt == 1) begin
        tif.mem_stall = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        tif.mem_stall = 1'b0;
        burst_req = 0;
      end else begin
        tif.mem_stall = stall_en && ($urandom_range(2) == 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input bit check_lat);
    tif.start = 1'b1;
    tick();
    tif.start = 1'b0;
    if (check_lat) begin
      check("start_wen", tif.wen, 1);
      check("start_data", tif.data, BEGIN_SYM);
    end
    check("start_busy", tif.busy, 1);
    check("start_cnt", tif.sent_count, 0);
    check("start_done", tif.done, 0);
  endtask

  task automatic produce(input int pct);
    int i = 0;
    int budget = 0;
    bit acc;
    while (i < words.size() && budget < 2000) begin
      tif.in_valid = ($urandom_range(99) < pct);
      tif.in_data  = words[i];
      tif.in_last  = (i == words.size() - 1);
      @(negedge clk);
      acc = tif.in_valid && tif.in_ready;
      if (tif.in_valid && !tif.in_ready) nready++;
      tick();
      tif.start = 1'b0;
      budget++;
      if (acc) begin
        i++;
        if (stray && i == 2) tif.start = 1'b1;
      end
    end
    tif.in_valid = 1'b0;
    check("produce_budget", i, words.size());
    tick();
    tif.start    = 1'b0;
    tif.in_valid = 1'b1;
    tif.in_data  = 32'hBAD0_0001;
    tif.in_last  = 1'b0;
    @(negedge clk);
    check("ready_after_last", tif.in_ready, 0);
    tick();
    tif.in_valid = 1'b0;
  endtask

  task automatic run_report(input int pct, input bit check_lat);
    int n = 0;
    exp_q = {};
    exp_q.push_back(BEGIN_SYM);
    foreach (words[k]) exp_q.push_back(words[k]);
    exp_q.push_back(END_SYM);
    comp_cnt   = 0;
    beat_len_q = {};
    do_start(check_lat);
    produce(pct);
    while (!tif.done && n < 3000) begin
      tick();
      n++;
    end
    check("done_timeout", n < 3000, 1);
    check("done", tif.done, 1);
    check("busy_done", tif.busy, 0);
    check("sent_count", tif.sent_count, words.size());
    check("writes_left", exp_q.size(), 0);
    check("ready_done", tif.in_ready, 0);
  endtask

  task automatic random_words();
    int n;
    n = $urandom_range(1, 12);
    words = {};
    for (int k = 0; k < n; k++)
      words.push_back(($urandom_range(3) == 0) ? 32'h0 : $urandom);
  endtask

  initial begin
    tif.start    = 1'b0;
    tif.in_valid = 1'b0;
    tif.in_data  = '0;
    tif.in_last  = 1'b0;

    rst = 1'b0;
    repeat (3) tick();
    check("rst_wen", tif.wen, 0);
    check("rst_addr", {2'b00, tif.addr}, 0);
    check("rst_data", tif.data, 0);
    check("rst_busy", tif.busy, 0);
    check("rst_done", tif.done, 0);
    check("rst_ready", tif.in_ready, 0);
    check("rst_cnt", tif.sent_count, 0);
    rst = 1'b1;
    tick();

    // Words offered before start are never taken
    tif.in_valid = 1'b1;
    tif.in_data  = 32'h55;
    tif.in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ready_idle", tif.in_ready, 0);
      tick();
    end
    tif.in_valid = 1'b0;

    words = {32'd0, 32'd1, 32'd1, 32'd2};
    burst_req = 1;
    run_report(100, 1);
    check("stall_beat_len", (beat_len_q.size() > 1) ? beat_len_q[1] : 0, 4);
    check("stall_beat_one", (beat_len_q.size() > 2) ? beat_len_q[2] : 0, 1);

    repeat (5) tick();
    stray = 1;
    run_report(70, 1);
    stray = 0;

    repeat (5) tick();
    words = {};
    for (int k = 0; k < 8; k++) words.push_back($urandom);
    nready = 0;
    run_report(100, 1);
    check("backpressure_seen", nready > 0, 1);

    stall_en = 1;
    for (int r = 0; r < 4; r++) begin
      repeat (5) tick();
      random_words();
      run_report(60, 1);
    end
    stall_en = 0;

    random_words();
    run_report(80, 0);
    random_words();
    run_report(100, 0);

    // Abort a report while the third result word is on the bus
    begin
      int i = 0;
      int n = 0;
      bit acc;
      repeat (5) tick();
      words = {};
      for (int k = 0; k < 10; k++) words.push_back($urandom | 32'h1);
      exp_q = {};
      exp_q.push_back(BEGIN_SYM);
      foreach (words[k]) exp_q.push_back(words[k]);
      comp_cnt = 0;
      do_start(1);
      while (!(tif.wen && comp_cnt == 3) && n < 200) begin
        tif.in_valid = (i < words.size());
        tif.in_data  = (i < words.size()) ? words[i] : 32'h0;
        tif.in_last  = 1'b0;
        @(negedge clk);
        acc = tif.in_valid && tif.in_ready;
        tick();
        if (acc) i++;
        n++;
      end
      check("reset_reach", n < 200, 1);
      tif.in_valid = 1'b0;
      rst = 1'b0;
      tick();
      check("abort_wen", tif.wen, 0);
      check("abort_addr", {2'b00, tif.addr}, 0);
      check("abort_data", tif.data, 0);
      check("abort_busy", tif.busy, 0);
      check("abort_done", tif.done, 0);
      check("abort_ready", tif.in_ready, 0);
      check("abort_cnt", tif.sent_count, 0);
      rst = 1'b1;
      tick();
    end

    words = {32'd0, 32'd1, 32'd1, 32'd2};
    run_report(100, 1);

    check("min_gap", min_gap, G);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
